// File: rtl/ninjin_ddr_resp_pkg.sv
// Shared types and constants for the ninjin DDR-side responder.
package ninjin_ddr_resp_pkg;

  localparam int BWIDTH_DEF  = 32;
  localparam int IMGSIZE_DEF = 12;

  // Burst tracker states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } resp_state_t;

  // First-error codes reported on err_code
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_COLL  = 2'd2;

  // One slot of the shared read pipeline. zero forces the completion to
  // return 0 (out-of-range or collision read); is_host steers the result
  // to the host port instead of ddr_rdata.
  typedef struct packed {
    logic                   valid;
    logic                   is_host;
    logic                   zero;
    logic [IMGSIZE_DEF-1:0] idx;
  } rd_stage_t;

endpackage

// File: rtl/ninjin_ddr_resp_if.sv
// Beat bus (DDR initiator side) plus host preload port of the responder.
interface ninjin_ddr_resp_if
  import ninjin_ddr_resp_pkg::*;
#(
  parameter int BWIDTH   = BWIDTH_DEF,
  parameter int IMGSIZE  = IMGSIZE_DEF,
  parameter int MEMDEPTH = 10
);
  logic                ddr_we;
  logic                ddr_re;
  logic [IMGSIZE-1:0]  ddr_addr;
  logic [BWIDTH-1:0]   ddr_wdata;
  logic [BWIDTH-1:0]   ddr_rdata;
  logic                host_req;
  logic                host_we;
  logic [MEMDEPTH-1:0] host_addr;
  logic [BWIDTH-1:0]   host_wdata;
  logic                host_gnt;
  logic [BWIDTH-1:0]   host_rdata;
  logic                host_rvalid;

  modport master (
    output ddr_we, ddr_re, ddr_addr, ddr_wdata,
    output host_req, host_we, host_addr, host_wdata,
    input  ddr_rdata, host_gnt, host_rdata, host_rvalid
  );

  modport slave (
    input  ddr_we, ddr_re, ddr_addr, ddr_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    output ddr_rdata, host_gnt, host_rdata, host_rvalid
  );
endinterface

// File: rtl/ninjin_ddr_resp_mem.sv
// Single-port word store with a registered read; contents survive reset.
module ninjin_resp_mem
  import ninjin_ddr_resp_pkg::*;
#(
  parameter int BWIDTH   = BWIDTH_DEF,
  parameter int MEMDEPTH = 10
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [MEMDEPTH-1:0] addr_i,
  input  logic [BWIDTH-1:0]   wdata_i,
  output logic [BWIDTH-1:0]   rdata_o
);
  logic [BWIDTH-1:0] mem_q [2**MEMDEPTH];
  logic [BWIDTH-1:0] rdata_q;

  // Write on we; read returns the pre-write contents of addr one cycle later
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ninjin_ddr_resp.sv
// DDR-side responder: word store behind the beat bus, fixed-latency reads,
// host side port that only gets the store when the DDR side is idle,
// plus a burst/beat tracker and a sticky first-error register.
module ninjin_ddr_resp
  import ninjin_ddr_resp_pkg::*;
#(
  parameter int BWIDTH    = BWIDTH_DEF,
  parameter int IMGSIZE   = IMGSIZE_DEF,
  parameter int MEMDEPTH  = 10,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  ninjin_ddr_resp_if.slave       bus,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic [15:0]            burst_count_o,
  output logic [31:0]            beat_count_o
);
  localparam logic [IMGSIZE:0] BASE_W  = (IMGSIZE+1)'(BASE_ADDR);
  localparam logic [IMGSIZE:0] DEPTH_W = (IMGSIZE+1)'(2**MEMDEPTH);

  // ---------------- address decode and arbitration ----------------
  logic                ddr_beat, coll, oor, host_gnt;
  logic [IMGSIZE:0]    off;
  logic [MEMDEPTH-1:0] mem_addr;
  logic                mem_we;
  logic [BWIDTH-1:0]   mem_wdata, mem_rdata;

  assign ddr_beat = bus.ddr_we | bus.ddr_re;
  assign coll     = bus.ddr_we & bus.ddr_re;
  // One extra bit so addresses below BASE_ADDR wrap to huge values
  assign off      = {1'b0, bus.ddr_addr} - BASE_W;
  assign oor      = ddr_beat & (off >= DEPTH_W);
  assign host_gnt = bus.host_req & ~ddr_beat;
  assign bus.host_gnt = host_gnt;

  assign mem_addr  = ddr_beat ? off[MEMDEPTH-1:0] : bus.host_addr;
  assign mem_we    = (bus.ddr_we & ~oor) | (host_gnt & bus.host_we);
  assign mem_wdata = bus.ddr_we ? bus.ddr_wdata : bus.host_wdata;

  ninjin_resp_mem #(.BWIDTH(BWIDTH), .MEMDEPTH(MEMDEPTH)) u_mem (
    .clk    (clk),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  // ---------------- shared read pipeline ----------------
  rd_stage_t         st_d;
  rd_stage_t         st_q [1:RD_LAT];
  logic [BWIDTH-1:0] done_data;

  // Issue slot: a DDR read, else a granted host read
  always_comb begin
    st_d         = '0;
    st_d.valid   = bus.ddr_re | (host_gnt & ~bus.host_we);
    st_d.is_host = ~bus.ddr_re;
    st_d.zero    = bus.ddr_re & (oor | bus.ddr_we);
    st_d.idx     = IMGSIZE_DEF'(mem_addr);
  end

  // Control shift register; reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= RD_LAT; k++) st_q[k] <= '0;
    end else begin
      st_q[1] <= st_d;
      for (int k = 2; k <= RD_LAT; k++) st_q[k] <= st_q[k-1];
    end
  end

  // Data follows the control: the store supplies stage 1, extra stages here
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign done_data = mem_rdata;
    end else begin : g_latn
      logic [BWIDTH-1:0] dpipe_q [2:RD_LAT];
      // Plain data delay line, qualified by the control valid bits
      always_ff @(posedge clk) begin
        dpipe_q[2] <= mem_rdata;
        for (int k = 3; k <= RD_LAT; k++) dpipe_q[k] <= dpipe_q[k-1];
      end
      assign done_data = dpipe_q[RD_LAT];
    end
  endgenerate

  logic              ddr_done, host_done;
  logic [BWIDTH-1:0] done_word, ddr_rdata_d, ddr_rdata_q, host_rdata_d, host_rdata_q;

  assign ddr_done     = st_q[RD_LAT].valid & ~st_q[RD_LAT].is_host;
  assign host_done    = st_q[RD_LAT].valid &  st_q[RD_LAT].is_host;
  assign done_word    = st_q[RD_LAT].zero ? '0 : done_data;
  assign ddr_rdata_d  = ddr_done  ? done_word : ddr_rdata_q;
  assign host_rdata_d = host_done ? done_word : host_rdata_q;

  assign bus.ddr_rdata   = ddr_rdata_d;
  assign bus.host_rdata  = host_rdata_d;
  assign bus.host_rvalid = host_done;

  // Each read port holds its last completion until its next one
  always_ff @(posedge clk) begin
    if (rst) begin
      ddr_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      ddr_rdata_q  <= ddr_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // ---------------- burst tracker ----------------
  resp_state_t        state_q, dir;
  logic [IMGSIZE-1:0] prev_addr_q;
  logic [15:0]        burst_q;
  logic [31:0]        beat_q;
  logic               new_burst;

  // A collision beat counts as a write
  assign dir       = bus.ddr_we ? WR : RD;
  assign new_burst = (state_q == IDLE) || (state_q != dir) ||
                     (bus.ddr_addr != prev_addr_q + IMGSIZE'(1));

  // FSM plus saturating burst/beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_addr_q <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
    end else if (ddr_beat) begin
      state_q     <= dir;
      prev_addr_q <= bus.ddr_addr;
      if (~&beat_q) beat_q <= beat_q + 32'd1;
      if (new_burst && ~&burst_q) burst_q <= burst_q + 16'd1;
    end else begin
      state_q <= IDLE;
    end
  end

  // ---------------- sticky error ----------------
  logic       err_q;
  logic [1:0] err_code_q;

  // First error wins; range beats out-rank a collision in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (!err_q && (oor || coll)) begin
      err_q      <= 1'b1;
      err_code_q <= oor ? ERR_RANGE : ERR_COLL;
    end
  end

  assign err_o         = err_q;
  assign err_code_o    = err_code_q;
  assign burst_count_o = burst_q;
  assign beat_count_o  = beat_q;
endmodule
